next_pc_unit: RTL
=================

Name: next_pc_unit

Overview:
- Program counter register and next-PC selection for the fetch stage.
- Consumes redirect targets from the execute-side adders: branch, JAL, and the one-cycle-delayed target from the JALR target adder.
- Owns the two-state handshake that covers the JALR adder's one-cycle latency.
- Drives the fetch address and a one-cycle flush to the fetch/decode register.

Parameters:
WORD_SIZE, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low; sampled at posedge clk; reset==0 initialises the block
stall  in  1  hold PC (hazard unit)
branch_taken  in  1  resolved taken conditional branch
branch_target  in  WORD_SIZE  branch target address
is_jal  in  1  JAL in decode
jal_target  in  WORD_SIZE  JAL target address
is_jalr  in  1  JALR in decode; same cycle imm is presented to JALR adder
jalr_target  in  WORD_SIZE  JALR adder output; valid exactly one cycle after is_jalr
pc  out  WORD_SIZE  current fetch address (registered)
pc_plus4  out  WORD_SIZE  pc + 4, combinational, mod 2^WORD_SIZE
flush  out  1  registered; kill instruction in fetch/decode register
busy  out  1  1 while state==JALR_WAIT
misalign_err  out  1  registered one-cycle pulse: rejected redirect target
err_addr  out  WORD_SIZE  last rejected target; holds until next error

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_PC, state=RUN, flush=0, misalign_err=0, err_addr=0. Reset overrides every other input, including mid-JALR_WAIT; the pending JALR is discarded.
- busy is decoded combinationally from state.
- Redirect with target T means: if T[1:0]==0, pc<=T and flush<=1 next cycle; otherwise pc holds, misalign_err<=1 next cycle, err_addr<=T, flush<=1.
- State RUN, per posedge, highest priority first:
  1. branch_taken: redirect to branch_target; stay in RUN.
  2. is_jalr: pc holds; go to JALR_WAIT; flush<=1 so the fall-through fetch is killed.
  3. is_jal: redirect to jal_target.
  4. stall: pc holds; flush<=0.
  5. Otherwise: pc<=pc+4, wrapping 32'hFFFF_FFFC to 32'h0; flush<=0.
- State JALR_WAIT (always exactly one cycle):
  - branch_taken: redirect to branch_target; the JALR is abandoned as wrong-path; go to RUN.
  - Otherwise: redirect to jalr_target; go to RUN.
  - stall, is_jal and is_jalr are ignored. jalr_target is valid only in this cycle.
  - jalr_target[0] always arrives as 0. A set jalr_target[1] is a misalignment.
- flush is high for exactly one cycle after every redirect, error or JALR entry. Otherwise flush is 0.
- Back-to-back redirects are accepted every cycle. No redirect is queued.
- pc never changes except as listed above.

Test Plan:
- Reset then free-run, RESET_PC=0 -> reset released; pc sequence 0,4,8,C; flush=0 throughout; pc_plus4=pc+4 each cycle.
- Wrap -> pc at 32'hFFFF_FFFC, no controls -> next pc=0, pc_plus4 at FFFF_FFFC reads 0.
- JALR handshake -> is_jalr at pc=0x10; next cycle jalr_target=0x200 -> pc holds 0x10 one cycle with busy=1 and flush=1; then pc=0x200 and flush=1 for one cycle; busy=0 after.
- Priority -> branch_taken=1 (0x80) with is_jal=1 (0x40) and stall=1 -> pc=0x80. Separately, branch_taken=1 (0x90) during JALR_WAIT with jalr_target=0x300 -> pc=0x90; state returns to RUN.
- Misalign -> is_jal with jal_target=0x102 at pc=0x20 -> pc stays 0x20; misalign_err=1 for one cycle; err_addr=0x102; flush=1. Same with jalr_target=0x106 -> err_addr=0x106.
- Reset mid-operation -> reset=0 in the JALR_WAIT cycle -> pc=RESET_PC, busy=0, flush=0; jalr_target ignored; stall asserted after reset holds pc at RESET_PC.

Source files
------------

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch-stage program counter with redirect and JALR wait handshake
module next_pc_unit #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 is_jal,
  input  logic [WORD_SIZE-1:0] jal_target,
  input  logic                 is_jalr,
  input  logic [WORD_SIZE-1:0] jalr_target,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pc_plus4,
  output logic                 flush,
  output logic                 busy,
  output logic                 misalign_err,
  output logic [WORD_SIZE-1:0] err_addr
);

  typedef enum logic {RUN, JALR_WAIT} state_t;

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] pc_next, err_addr_next, target;
  logic                 flush_next, err_next, redirect;

  assign pc_plus4 = pc + WORD_SIZE'(4);
  assign busy     = (state == JALR_WAIT);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    flush_next    = 1'b0;
    err_next      = 1'b0;
    err_addr_next = err_addr;
    redirect      = 1'b0;
    target        = '0;

    case (state)
      RUN: begin
        if (branch_taken) begin
          redirect = 1'b1;
          target   = branch_target;
        end else if (is_jalr) begin
          // Hold pc while the JALR adder settles; kill the fall-through fetch.
          state_next = JALR_WAIT;
          flush_next = 1'b1;
        end else if (is_jal) begin
          redirect = 1'b1;
          target   = jal_target;
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      JALR_WAIT: begin
        state_next = RUN;
        redirect   = 1'b1;
        target     = branch_taken ? branch_target : jalr_target;
      end
      default: state_next = RUN;
    endcase

    if (redirect) begin
      flush_next = 1'b1;
      if (target[1:0] == 2'b00) begin
        pc_next = target;
      end else begin
        err_next      = 1'b1;
        err_addr_next = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      flush        <= flush_next;
      misalign_err <= err_next;
      err_addr     <= err_addr_next;
    end
  end

endmodule
